// File: rtl/mul_seq_ctrl_pkg.sv
// Shared encodings for the execute-stage multiply sequencer: FSM states,
// the MUL command code and the {N,Z,C,V} bit positions.
package mul_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] EXE_CMD_MUL = 4'b0010;

    localparam int unsigned SR_N = 3;
    localparam int unsigned SR_Z = 2;
    localparam int unsigned SR_C = 1;
    localparam int unsigned SR_V = 0;

    function automatic logic [3:0] mk_status(input logic [31:0] acc,
                                             input logic        c,
                                             input logic        v);
        logic [3:0] st;
        st       = '0;
        st[SR_N] = acc[31];
        st[SR_Z] = (acc == 32'd0);
        st[SR_C] = c;
        st[SR_V] = v;
        return st;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Execute-stage <-> multiply sequencer bundle; the pipeline side is master.
interface mul_seq_ctrl_if;
    logic        start;
    logic        flush;
    logic        S;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic [3:0]  statusRegs_IN;
    logic        freeze;
    logic        done;
    logic [31:0] res;
    logic [3:0]  status_out;
    logic        status_wr;

    modport master (
        output start, flush, S, Val_Rn, Val_Rm, statusRegs_IN,
        input  freeze, done, res, status_out, status_wr
    );

    modport slave (
        input  start, flush, S, Val_Rn, Val_Rm, statusRegs_IN,
        output freeze, done, res, status_out, status_wr
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Radix-2 shift-add multiplier (low 32 bits) with early exit on an exhausted multiplier.
// Latency: done h+2 cycles after start (h = top set bit of Rm), 1 cycle for a zero operand.
// Backpressure: freeze stalls IF/ID/EXE from the accept cycle through the last RUN cycle.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
(
    input logic           clk,
    input logic           rst,
    mul_seq_ctrl_if.slave bus
);

    state_e      state_q;
    logic [31:0] mcand_q, mplier_q, acc_q, res_q;
    logic [4:0]  cnt_q;
    logic        s_q, c_q, v_q;

    logic        accept, out_vld;
    logic [31:0] acc_d, mcand_d, mplier_d;
    logic [4:0]  cnt_d;

    assign accept   = (state_q == ST_IDLE) & bus.start & ~bus.flush;
    assign out_vld  = (state_q == ST_DONE) & ~bus.flush;

    assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mcand_d  = {mcand_q[30:0], 1'b0};
    assign mplier_d = {1'b0, mplier_q[31:1]};
    assign cnt_d    = cnt_q + 5'd1;

    // Outside a valid DONE cycle the last completed product is shown, never acc.
    assign bus.freeze     = accept | (state_q == ST_RUN);
    assign bus.done       = out_vld;
    assign bus.res        = out_vld ? acc_q : res_q;
    assign bus.status_out = out_vld ? mk_status(acc_q, c_q, v_q) : 4'd0;
    assign bus.status_wr  = out_vld & s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            s_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        mcand_q  <= bus.Val_Rn;
                        mplier_q <= bus.Val_Rm;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        s_q      <= bus.S;
                        c_q      <= bus.statusRegs_IN[SR_C];
                        v_q      <= bus.statusRegs_IN[SR_V];
                        if ((bus.Val_Rn == 32'd0) || (bus.Val_Rm == 32'd0))
                            state_q <= ST_DONE;
                        else
                            state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        cnt_q    <= cnt_d;
                        if ((mplier_d == 32'd0) || (cnt_q == 5'd31))
                            state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A start seen here is deliberately not accepted.
                    if (out_vld)
                        res_q <= acc_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: expected products queued at stimulus time, checked on done.
module tb_mul_seq_ctrl;

    logic clk;
    logic rst;
    mul_seq_ctrl_if bus ();

    mul_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  st;
        logic        wr;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_res = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] rn, input logic [31:0] rm,
                                   input logic s, input logic [3:0] st);
        exp_t        e;
        logic [31:0] p;
        int          h;
        p = rn * rm;
        h = 0;
        for (int i = 0; i < 32; i++)
            if (rm[i]) h = i;
        e.res = p;
        e.st  = {p[31], (p == 32'd0), st[1], st[0]};
        e.wr  = s;
        e.lat = ((rn == 32'd0) || (rm == 32'd0)) ? 1 : h + 2;
        return e;
    endfunction

    // Entered and left at posedge+1. Cycle 0 is the start cycle.
    task automatic run_one(input logic [31:0] rn, input logic [31:0] rm,
                           input logic s, input logic [3:0] st);
        exp_t e;
        int   n;
        bit   got;
        sb.push_back(model(rn, rm, s, st));
        bus.start = 1'b1; bus.Val_Rn = rn; bus.Val_Rm = rm;
        bus.S = s; bus.statusRegs_IN = st;
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (bus.done) begin
                e = sb.pop_front();
                chk("latency", 32'(n), 32'(e.lat));
                chk("res", bus.res, e.res);
                chk("status_out", 32'(bus.status_out), 32'(e.st));
                chk("status_wr", 32'(bus.status_wr), 32'(e.wr));
                chk("freeze_in_done", 32'(bus.freeze), 32'd0);
                last_res = e.res;
                got = 1;
            end else begin
                chk("freeze_busy", 32'(bus.freeze), 32'd1);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            n++;
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("done_single_pulse", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2;
        int   n, ndone;

        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.S = 1'b0;
        bus.Val_Rn = '0; bus.Val_Rm = '0; bus.statusRegs_IN = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_freeze", 32'(bus.freeze), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_status_wr", 32'(bus.status_wr), 32'd0);
        chk("rst_res", bus.res, 32'd0);
        chk("rst_status_out", 32'(bus.status_out), 32'd0);
        @(posedge clk); #1;

        run_one(32'd3, 32'd5, 1'b1, 4'b0011);
        run_one(32'h12345678, 32'd0, 1'b1, 4'b0000);
        run_one(32'd7, 32'd1, 1'b1, 4'b0000);
        run_one(32'hFFFFFFFF, 32'h80000000, 1'b0, 4'b0000);
        for (int k = 0; k < 4; k++)
            run_one($urandom, $urandom >> $urandom_range(0, 31), 1'($urandom), 4'($urandom));
        run_one(32'd11, 32'd13, 1'b1, 4'b1010);

        // Flush in cycle 2 of a RUN: no done, prior product stays visible.
        bus.start = 1'b1; bus.Val_Rn = 32'd2; bus.Val_Rm = 32'hF; bus.S = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1 bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_done", 32'(bus.done), 32'd0);
        chk("flush_status_wr", 32'(bus.status_wr), 32'd0);
        chk("flush_res", bus.res, last_res);
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_freeze", 32'(bus.freeze), 32'd0);
        chk("flush_idle_res", bus.res, last_res);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("flush_no_done", 32'(bus.done), 32'd0);
        end
        @(posedge clk); #1;

        // Start held across two MULs; the second must wait for the cycle after DONE.
        e1 = model(32'd3, 32'd5, 1'b1, 4'b0001);
        e2 = model(32'd6, 32'd1, 1'b0, 4'b0001);
        sb.push_back(e1);
        sb.push_back(e2);
        bus.start = 1'b1; bus.Val_Rn = 32'd3; bus.Val_Rm = 32'd5;
        bus.S = 1'b1; bus.statusRegs_IN = 4'b0001;
        n = 0; ndone = 0;
        while (ndone < 2 && n < 30) begin
            @(negedge clk);
            if (n == e1.lat)     chk("b2b_freeze_done", 32'(bus.freeze), 32'd0);
            if (n == e1.lat + 1) chk("b2b_freeze_accept", 32'(bus.freeze), 32'd1);
            if (bus.done) begin
                exp_t e;
                e = sb.pop_front();
                chk("b2b_cycle", 32'(n), (ndone == 0) ? 32'(e1.lat) : 32'(e1.lat + 1 + e2.lat));
                chk("b2b_res", bus.res, e.res);
                chk("b2b_status_wr", 32'(bus.status_wr), 32'(e.wr));
                last_res = e.res;
                ndone++;
            end
            @(posedge clk); #1;
            if (n == 0) begin
                bus.Val_Rn = 32'd6; bus.Val_Rm = 32'd1; bus.S = 1'b0;
            end
            n++;
        end
        bus.start = 1'b0;
        if (ndone < 2) chk("b2b_timeout", 32'(ndone), 32'd2);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a long RUN.
        bus.start = 1'b1; bus.Val_Rn = 32'hFFFFFFFF; bus.Val_Rm = 32'h80000000;
        bus.S = 1'b1; bus.statusRegs_IN = 4'b0011;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_freeze", 32'(bus.freeze), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_status_wr", 32'(bus.status_wr), 32'd0);
        chk("arst_res", bus.res, 32'd0);
        chk("arst_status_out", 32'(bus.status_out), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run_one(32'd9, 32'd9, 1'b1, 4'b0000);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle multiply sequencer for the execute stage. It accepts a MUL command with both register operands already resolved. It computes the low 32 bits of Val_Rn × Val_Rm with a radix-2 shift-add loop that terminates early, and it holds the pipeline with `freeze` until the result is ready. The execute-stage result mux selects `res` while `done` is high, and the status register takes `status_out` when `status_wr` is high.

## Interface
- No parameters. Width is fixed at 32; the iteration counter is 5 bits.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: a MUL command is present in the execute stage.
- `flush` input 1: branch flush. Aborts any operation in progress.
- `S` input 1: update-flags bit of the instruction.
- `Val_Rn` input 32: multiplicand.
- `Val_Rm` input 32: multiplier.
- `statusRegs_IN` input 4: current {N,Z,C,V}.
- `freeze` output 1: stall the IF, ID and EXE pipeline registers.
- `done` output 1: one-cycle pulse; `res` is valid.
- `res` output 32: product, low 32 bits.
- `status_out` output 4: {N,Z,C,V} to write back.
- `status_wr` output 1: status register write enable.

## Operation
- States: IDLE, RUN, DONE.
- **Accept.** In IDLE, if `start`=1 and `flush`=0, the block latches the operands on the next rising edge:
  - `mcand` = Val_Rn, `mplier` = Val_Rm, `acc` = 0, `cnt` = 0.
  - It also latches S and the C and V bits of statusRegs_IN.
- **Zero operand.** If Val_Rn==0 or Val_Rm==0 at accept, the block goes IDLE→DONE with `acc` = 0. Otherwise it goes IDLE→RUN.
- **RUN, each cycle:**
  - If mplier[0]=1, then acc = acc + mcand (mod 2^32).
  - mcand <<= 1, mplier >>= 1, cnt++.
  - The block goes to DONE when the shifted mplier is 0 or cnt==31.
- **DONE:**
  - `done`=1 and `res`=acc.
  - `status_out` = {acc[31], acc==0, C_latched, V_latched}.
  - `status_wr` = S_latched.
  - Next state is IDLE unconditionally. A `start` seen during DONE is ignored, because the pipeline advances in that cycle and the next MUL is sampled in IDLE.
- **Flush.** A flush in RUN or DONE forces IDLE on the next edge. `done` and `status_wr` are gated to 0 in that cycle, and `acc` is not exposed.
- **freeze** = (IDLE & start & ~flush) | RUN. It is combinational so that the stall begins in the accept cycle.
- **res** holds the last completed product until the next accept. It is not cleared on return to IDLE.

## Timing
- **Reset values:**
  - State = IDLE.
  - freeze=0, done=0, status_wr=0, res=0, status_out=0.
  - All internal registers = 0.
- **Latency.** Let h be the index of the highest set bit of Val_Rm.
  - `done` goes high h+2 cycles after the start cycle.
  - If either operand is 0, `done` goes high 1 cycle after the start cycle.
  - Best case is 2 cycles (Rm=1). Worst case is 33 cycles (Rm bit 31 set).
- **freeze span.** `freeze` is high from the start cycle through the last RUN cycle, and low in the DONE cycle.
- **No back-to-back accept.** A new MUL cannot be accepted in the DONE cycle. The minimum spacing between accepts is latency+1 cycles.
- **Reset mid-operation.** Reset takes effect immediately and asynchronously. The operation in progress is lost.

## Structure
- A shared package holds the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the EXE_CMD code for MUL, and the status bit positions N=3, Z=2, C=1, V=0.
- The design is a single module with no sub-modules. The adder and shifters stay inline, and the FSM and datapath live in one file.

## Test plan
- Val_Rn=3, Val_Rm=5, S=1, statusRegs_IN=4'b0011 → freeze high for cycles 0–3; done in cycle 4; res=15; status_out=4'b0011; status_wr=1.
- Val_Rn=0x12345678, Val_Rm=0 → done in cycle 1, res=0, status_out Z=1; and Rn=7, Rm=1 → done in cycle 2, res=7.
- Val_Rn=0xFFFFFFFF, Val_Rm=0x80000000, S=0 → done in cycle 33; res=0x80000000; N=1; status_wr=0.
- Rn=2, Rm=0xF: assert flush in cycle 2 → IDLE in cycle 3, freeze=0, no done pulse, res unchanged from the prior result.
- Two MULs with start held continuously: the second is accepted only in the cycle after the first's DONE, with no double accept in the DONE cycle.
- Assert rst asynchronously mid-RUN → all outputs return to their reset values before the next clock edge.
